// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl
// Run-time controller for the clock divider. It owns the period counter and
// selects ratio 2, 3, 4, 6 or 8 through a valid/ready configuration port.
// Ratio changes and stop requests are applied only at a period boundary, so
// clk_out and step never produce a runt pulse.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   en         run request (0 = stop at the next period boundary)
//   cfg_valid  configuration request present
//   cfg_sel    ratio code: 0=div2 1=div3 2=div4 3=div6 4=div8, 5-7 invalid
//   cfg_ready  configuration can be accepted this cycle
//   cfg_err    one-cycle pulse the cycle after an invalid code is accepted
//   cur_sel    ratio code currently in effect
//   clk_out    divided clock (flop output)
//   step       pulse in the last cycle of each period (flop output)
//   busy       high in RUN, SWITCH and DRAIN
//
// state  | meaning
// IDLE   | counter held at 0, outputs low
// RUN    | counting at cur_sel
// SWITCH | counting, a new ratio waits for the boundary
// DRAIN  | finishing the current period, then IDLE
module clkdiv_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       cfg_valid,
  input  logic [2:0] cfg_sel,
  output logic       cfg_ready,
  output logic       cfg_err,
  output logic [2:0] cur_sel,
  output logic       clk_out,
  output logic       step,
  output logic       busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] SWITCH = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  // Last count value of a period (N-1). Only valid codes are ever stored.
  function automatic logic [CNT_W-1:0] last_cnt(input logic [2:0] sel);
    case (sel)
      3'd0:    return CNT_W'(1);
      3'd1:    return CNT_W'(2);
      3'd2:    return CNT_W'(3);
      3'd3:    return CNT_W'(5);
      default: return CNT_W'(7);
    endcase
  endfunction

  // High-phase length N/2 (integer divide); clk_out is high while cnt < this.
  function automatic logic [CNT_W-1:0] half_cnt(input logic [2:0] sel);
    case (sel)
      3'd0:    return CNT_W'(1);
      3'd1:    return CNT_W'(1);
      3'd2:    return CNT_W'(2);
      3'd3:    return CNT_W'(3);
      default: return CNT_W'(4);
    endcase
  endfunction

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_adv;
  logic [2:0]       cur_sel_n;
  logic [2:0]       pend_sel, pend_sel_n;
  logic             pend_vld, pend_vld_n;
  logic             err_n, clk_out_n, step_n, run_n;
  logic             xfer, code_ok, acc, boundary;

  assign cfg_ready = (state == IDLE) || (state == RUN);
  assign busy      = (state != IDLE);
  assign xfer      = cfg_valid && cfg_ready;
  assign code_ok   = (cfg_sel <= 3'd4);
  assign acc       = xfer && code_ok;
  assign boundary  = (cnt == last_cnt(cur_sel));
  assign cnt_adv   = boundary ? '0 : cnt + CNT_W'(1);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    cur_sel_n  = cur_sel;
    pend_sel_n = pend_sel;
    pend_vld_n = pend_vld;
    err_n      = xfer && !code_ok;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (acc) cur_sel_n = cfg_sel;
        if (en)  state_n = RUN;
      end
      RUN: begin
        cnt_n = cnt_adv;
        // A code accepted on the boundary cycle itself governs the very next
        // period, so it is committed directly instead of going pending.
        if (acc && boundary) begin
          cur_sel_n = cfg_sel;
        end else if (acc) begin
          pend_sel_n = cfg_sel;
          pend_vld_n = 1'b1;
        end
        if (!en)                   state_n = DRAIN;
        else if (acc && !boundary) state_n = SWITCH;
      end
      SWITCH: begin
        cnt_n = cnt_adv;
        if (boundary) begin
          cur_sel_n  = pend_sel;
          pend_vld_n = 1'b0;
          state_n    = en ? RUN : DRAIN;
        end else if (!en) begin
          state_n = DRAIN;
        end
      end
      default: begin
        cnt_n = cnt_adv;
        if (boundary) begin
          state_n    = IDLE;
          cnt_n      = '0;
          pend_vld_n = 1'b0;
          if (pend_vld) cur_sel_n = pend_sel;
        end
      end
    endcase

    // Outputs are registered from the next-cycle count and ratio so that
    // clk_out/step line up with cnt while still coming straight off a flop.
    run_n     = (state_n != IDLE);
    clk_out_n = run_n && (cnt_n < half_cnt(cur_sel_n));
    step_n    = run_n && (cnt_n == last_cnt(cur_sel_n));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_sel  <= 3'd0;
      pend_sel <= 3'd0;
      pend_vld <= 1'b0;
      cfg_err  <= 1'b0;
      clk_out  <= 1'b0;
      step     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cur_sel  <= cur_sel_n;
      pend_sel <= pend_sel_n;
      pend_vld <= pend_vld_n;
      cfg_err  <= err_n;
      clk_out  <= clk_out_n;
      step     <= step_n;
    end
  end

endmodule

// File: doc/clkdiv_ctrl.md
# clkdiv_ctrl

Run-time controller for the clock-divider resource. It owns the divide counter and sequences ratio changes, selecting one of the ratios 2, 3, 4, 6 or 8 through a valid/ready configuration port. Ratio changes and stop requests take effect only on a period boundary, so the divided clock and the step strobe never produce a runt pulse. The block sits between the system configuration logic and every consumer of the divided clock and step enable.

## Interface
- CNT_W, default 4: width of the period counter; must hold 7 (the largest ratio minus 1).
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  run request: 1 = run the divider, 0 = stop at the next period boundary.
- cfg_valid  in  1  a configuration request is present.
- cfg_sel  in  3  ratio code: 0=div2, 1=div3, 2=div4, 3=div6, 4=div8; codes 5-7 are invalid.
- cfg_ready  out  1  the block can accept a configuration this cycle.
- cfg_err  out  1  one-cycle pulse, one cycle after an invalid code is accepted.
- cur_sel  out  3  ratio code currently in effect.
- clk_out  out  1  divided clock, driven directly by a flop.
- step  out  1  one-cycle pulse in the last cycle of each period, driven directly by a flop.
- busy  out  1  high in the RUN, SWITCH and DRAIN states.

## Operation
- **States:**
  - IDLE: counter held at 0, clk_out=0, step=0.
  - RUN: counting at the current ratio.
  - SWITCH: counting, with a pending ratio.
  - DRAIN: finishing the current period before stopping.
- **Ratio N:** N = ratio(cur_sel). Within a period, cnt runs 0..N-1.
  - clk_out = 1 while cnt < N/2 (integer divide). div3 gives high 1 cycle, low 2 cycles.
  - step = 1 only when cnt = N-1.
- **Boundary:** the cycle where cnt = N-1.
- **Handshake:**
  - cfg_ready = 1 in IDLE and RUN, and 0 in SWITCH and DRAIN.
  - A transfer occurs when cfg_valid && cfg_ready.
  - cfg_sel is sampled only on a transfer.
- **Invalid code:** the transfer completes, cfg_err pulses on the next cycle, and there is no state or ratio change.
- **Transfer in IDLE:** cur_sel updates on the next cycle.
- **Transfer in RUN:** the code is stored as pending and the state goes to SWITCH. At the next boundary, cur_sel takes the pending value, cnt restarts at 0, and the state returns to RUN. If the transfer cycle is itself a boundary, the new ratio applies from the next period.
- **IDLE→RUN:** when en=1.
- **en=0 in RUN or SWITCH:** the state goes to DRAIN. Any pending ratio is kept.
- **DRAIN:**
  - At the boundary, the state goes to IDLE and any pending ratio is committed to cur_sel.
  - en returning to 1 in DRAIN does not cancel the drain. The block restarts from IDLE afterwards.
- **Simultaneous en=0 and a valid transfer in RUN:** the ratio is stored as pending and the state goes to DRAIN.
- **Reset values:** state IDLE, cur_sel=0 (div2), cnt=0, pending cleared, clk_out=0, step=0, cfg_err=0, busy=0.
- **Reset mid-operation:** all registers take their reset values on the next edge, and any pending ratio is discarded.

## Timing
- en=1 sampled in IDLE at edge t: from t+1 the state is RUN, cnt=0 and clk_out=1.
  - First step pulse appears at cycle t+N.
  - Then one step every N cycles.
- cfg accept in IDLE: the new cur_sel is visible one cycle later.
- cfg accept in RUN: the new ratio governs from the cycle after the next boundary. Latency is 1..N cycles.
- cfg_err: exactly 1 cycle wide, 1 cycle after acceptance.
- Stop: clk_out=0 and busy=0 from the cycle after the boundary at which DRAIN exits.
- step and clk_out never change mid-period. No period is ever shorter than min(old N, new N).

## Test plan
- **Reset, then en=1 at div2:** clk_out toggles 1,0,1,0...; step is high on every second cycle, aligned with clk_out=0. busy=1.
- **Running div4, write cfg_sel=1 (div3) mid-period:** cfg_ready=0 until the boundary. The current period completes as 4 cycles (clk_out 1,1,0,0). Following periods are 3 cycles (clk_out 1,0,0). cur_sel=1.
- **Write cfg_sel=6:** cfg_err pulses once, one cycle later. cur_sel and the clk_out period are unchanged.
- **Running div8, drop en at cnt=2:** clk_out completes the period (low through cnt=7). step fires at cnt=7, then IDLE with clk_out=0 and busy=0.
- **Running div6, assert reset at cnt=3:** on the next cycle clk_out=0, step=0, cur_sel=0 and busy=0. en=1 afterwards restarts at div2.
- **Running div2, same cycle: en=0 and cfg_sel=4:** drain to IDLE, with cur_sel=4 on IDLE entry. Then en=1 gives 8-cycle periods with clk_out high for 4 cycles.
